// File: rtl/seq_divider_if.sv
// Start/done handshake bundle between the controlling sequencer and seq_divider.
// start is taken only while busy=0; done pulses one cycle and results hold until the next accepted start.
interface seq_divider_if #(
  parameter int W = 4
);
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Divide-by-zero spends one RUN cycle so its done arrives one edge after the accepting edge.
module seq_divider #(
  parameter int W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  seq_divider_if.slave      bus,
  output logic [1:0]        o_dbg_state
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [W-1:0]  r_d;
  logic [W-1:0]  r_q;
  logic [W-1:0]  r_rem;
  logic [CW-1:0] r_cnt;
  logic          r_zero;
  logic [W-1:0]  r_quot;
  logic [W-1:0]  r_remd;
  logic          r_dbz;

  logic [W:0]    w_shift_r;
  logic [W:0]    w_trial;
  logic          w_ge;
  logic [W-1:0]  w_q_next;
  logic [W-1:0]  w_r_next;

  // Shifted R is below 2*D, so the W+1 bit trial never wraps: its top bit is the borrow.
  always_comb begin
    w_shift_r = {r_rem, r_q[W-1]};
    w_trial   = w_shift_r + ~{1'b0, r_d} + {{W{1'b0}}, 1'b1};
    w_ge      = ~w_trial[W];
    w_q_next  = {r_q[W-2:0], w_ge};
    w_r_next  = w_ge ? w_trial[W-1:0] : w_shift_r[W-1:0];
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_RUN;
      S_RUN:   if (r_zero || (r_cnt == LAST)) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d    <= '0;
      r_q    <= '0;
      r_rem  <= '0;
      r_cnt  <= '0;
      r_zero <= 1'b0;
      r_quot <= '0;
      r_remd <= '0;
      r_dbz  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_d    <= bus.divisor;
            r_q    <= bus.dividend;
            r_rem  <= '0;
            r_cnt  <= '0;
            r_zero <= (bus.divisor == '0);
            r_dbz  <= 1'b0;
          end
        end
        S_RUN: begin
          if (r_zero) begin
            r_quot <= '1;
            r_remd <= r_q;
            r_dbz  <= 1'b1;
          end else begin
            r_q   <= w_q_next;
            r_rem <= w_r_next;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == LAST) begin
              r_quot <= w_q_next;
              r_remd <= w_r_next;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (r_state != S_IDLE);
  assign bus.done        = (r_state == S_DONE);
  assign bus.quotient    = r_quot;
  assign bus.remainder   = r_remd;
  assign bus.div_by_zero = r_dbz;
  assign o_dbg_state     = r_state;

endmodule
